motoro3_line_step_sequencer: RTL
================================

# motoro3_line_step_sequencer

Time base for the 3-phase line calculator. Drives the 4-bit line step `lcStep` into `motoro3_line_calc_parameter` and takes back that stage's per-step results:
- `plLen`: PWM period length in clocks.
- `slLen`: number of PWM periods spent on the current step.

It latches both once per step, counts PWM periods and steps, and emits period/step/cycle strobes to the PWM output stage.

## Interface
- `LAST_STEP`, default 4'd15: final step index; `lcStep` wraps from here to 0.
- `MIN_PL`, default 16'd2: minimum effective PWM period in clocks.
- `clk` input 1: system clock; all logic on rising edge.
- `nRst` input 1: asynchronous, active-low reset.
- `m3r_stepEnable` input 1: run request; level-sensitive.
- `plLen` input 16: PWM period length for the current `lcStep`. Combinational from the upstream stage.
- `slLen` input 16: PWM periods per step for the current `lcStep`. Combinational from the upstream stage.
- `lcStep` output 4: current line step, registered.
- `pwmCnt` output 16: clock position inside the current PWM period.
- `pwmStart` output 1: high on the first clock of each PWM period.
- `stepStart` output 1: high on the first clock of each step's first PWM period.
- `lineCycleDone` output 1: one-clock pulse when `lcStep` wraps from `LAST_STEP` to 0.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, SETTLE, RUN. Held in a registered state variable.
- **IDLE**
  - Outputs: `lcStep`=0, `pwmCnt`=0, period counter `perCnt`=0, all strobes 0.
  - Transition: `m3r_stepEnable`=1 → SETTLE.
- **SETTLE** (exactly 1 clock)
  - Purpose: lets the upstream combinational paths settle on the new `lcStep`.
  - On exit, latch `plLenR` = max(`plLen`, `MIN_PL`).
  - On exit, latch `slLenR` = (`slLen`==0) ? 1 : `slLen`.
  - Clear `pwmCnt` and `perCnt`, then → RUN.
- **RUN**
  - `pwmCnt` increments each clock and wraps at `plLenR`-1.
  - On each wrap, `perCnt` increments.
  - When `pwmCnt`==`plLenR`-1 and `perCnt`==`slLenR`-1 (end of step):
    - `lcStep` ← (`lcStep`==`LAST_STEP`) ? 0 : `lcStep`+1.
    - → SETTLE.
    - `lineCycleDone` pulses on the clock after a `LAST_STEP`→0 wrap (registered).
- `plLen`/`slLen` changes during RUN are ignored until the next SETTLE.
- `m3r_stepEnable`=0 in SETTLE or RUN → IDLE on the next edge.
  - All counters and `lcStep` clear.
  - No `lineCycleDone` is generated.
  - Re-enable restarts from step 0.
- Strobes are decoded from registered state only:
  - `pwmStart` = RUN & `pwmCnt`==0.
  - `stepStart` = `pwmStart` & `perCnt`==0.
- Arithmetic:
  - Counters are 16-bit unsigned.
  - Terminal compares use the latched values minus 1.
  - The guards above make an underflow impossible.

## Timing
- Reset (`nRst`=0, asynchronous):
  - State IDLE.
  - `lcStep`=0, `pwmCnt`=0, `perCnt`=0, `plLenR`=`MIN_PL`, `slLenR`=1.
  - `pwmStart`=`stepStart`=`lineCycleDone`=`busy`=0.
  - Reset is honoured mid-operation with no completion pulse.
- Enable sampled high at edge N:
  - SETTLE during cycle N+1 (`busy`=1).
  - RUN from N+2, with `pwmStart`=`stepStart`=1 in that cycle.
- Step duration is `slLenR`×`plLenR`+1 clocks; the +1 is SETTLE.
- Full line cycle is the sum of the per-step durations over steps 0..`LAST_STEP`.
- `lcStep` changes on the same edge that enters SETTLE. Upstream outputs are sampled one full clock later.
- `pwmCnt` holds 0 during SETTLE.
- Enable low and end-of-step on the same edge: disable wins; the step does not advance.

## Test plan
- **Constant lengths:** `plLen`=4, `slLen`=3, enable held.
  - Each step is 13 clocks; `lcStep` runs 0..15.
  - `lineCycleDone` pulses once, 208 clocks after the first RUN cycle.
  - `pwmStart` appears 48 times per line cycle; `stepStart` appears 16 times.
- **Zero guards:** `plLen`=0, `slLen`=0.
  - Each step lasts 2×1+1=3 clocks; `pwmCnt` toggles 0,1.
  - No lockup and no counter underflow.
- **Mid-step length change:** `plLen` changes from 4 to 6 in the middle of step 2.
  - Step 2 keeps period 4.
  - Step 3 uses 6, with the change latched in SETTLE.
- **Disable mid-RUN:** drop `m3r_stepEnable` at step 5, `pwmCnt`=2.
  - Next cycle: IDLE, `lcStep`=0, `busy`=0, no `lineCycleDone`.
  - Re-enable restarts at step 0 after 1 SETTLE cycle.
- **Async reset mid-RUN:** pulse `nRst` low for a partial cycle.
  - All outputs go to their reset values immediately.
  - Recovery requires enable high → SETTLE → RUN.
- **LAST_STEP=4'd5:** `lcStep` cycles 0..5 and `lineCycleDone` pulses at each 5→0 wrap.

Source files
------------

// File: rtl/motoro3_line_step_sequencer.sv
// Line step time base for the 3-phase line calculator: walks lcStep through the
// line, latching the upstream period/step lengths once per step and counting PWM periods.
module motoro3_line_step_sequencer #(
  parameter logic [3:0]  LAST_STEP = 4'd15,
  parameter logic [15:0] MIN_PL    = 16'd2
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3r_stepEnable,
  input  logic [15:0] plLen,
  input  logic [15:0] slLen,
  output logic [3:0]  lcStep,
  output logic [15:0] pwmCnt,
  output logic        pwmStart,
  output logic        stepStart,
  output logic        lineCycleDone,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lc_step_q, lc_step_d;
  logic [15:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] pl_len_q, pl_len_d;
  logic [15:0] sl_len_q, sl_len_d;
  logic        wrap_q, wrap_d;
  logic        line_done_q, line_done_d;
  logic        pwm_last;
  logic        step_last;

  always_comb begin
    // NOTE: every *_d gets its default first, so no path leaves a latch behind.
    state_d     = state_q;
    lc_step_d   = lc_step_q;
    pwm_cnt_d   = pwm_cnt_q;
    per_cnt_d   = per_cnt_q;
    pl_len_d    = pl_len_q;
    sl_len_d    = sl_len_q;
    wrap_d      = 1'b0;
    line_done_d = 1'b0;

    // Latched lengths are never below 1, so the minus-one compares cannot underflow.
    pwm_last  = (pwm_cnt_q == pl_len_q - 16'd1);
    step_last = pwm_last && (per_cnt_q == sl_len_q - 16'd1);

    unique case (state_q)
      ST_IDLE: begin
        lc_step_d = 4'd0;
        pwm_cnt_d = 16'd0;
        per_cnt_d = 16'd0;
        if (m3r_stepEnable) state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        pwm_cnt_d = 16'd0;
        per_cnt_d = 16'd0;
        if (!m3r_stepEnable) begin
          state_d   = ST_IDLE;
          lc_step_d = 4'd0;
        end else begin
          pl_len_d    = (plLen < MIN_PL) ? MIN_PL : plLen;
          sl_len_d    = (slLen == 16'd0) ? 16'd1 : slLen;
          line_done_d = wrap_q;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!m3r_stepEnable) begin
          // Disable beats a coincident end-of-step: no advance, no completion pulse.
          state_d   = ST_IDLE;
          lc_step_d = 4'd0;
          pwm_cnt_d = 16'd0;
          per_cnt_d = 16'd0;
        end else if (step_last) begin
          lc_step_d = (lc_step_q == LAST_STEP) ? 4'd0 : lc_step_q + 4'd1;
          wrap_d    = (lc_step_q == LAST_STEP);
          pwm_cnt_d = 16'd0;
          per_cnt_d = 16'd0;
          state_d   = ST_SETTLE;
        end else if (pwm_last) begin
          pwm_cnt_d = 16'd0;
          per_cnt_d = per_cnt_q + 16'd1;
        end else begin
          pwm_cnt_d = pwm_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      lc_step_q   <= 4'd0;
      pwm_cnt_q   <= 16'd0;
      per_cnt_q   <= 16'd0;
      pl_len_q    <= MIN_PL;
      sl_len_q    <= 16'd1;
      wrap_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      lc_step_q   <= lc_step_d;
      pwm_cnt_q   <= pwm_cnt_d;
      per_cnt_q   <= per_cnt_d;
      pl_len_q    <= pl_len_d;
      sl_len_q    <= sl_len_d;
      wrap_q      <= wrap_d;
      line_done_q <= line_done_d;
    end
  end

  assign lcStep        = lc_step_q;
  assign pwmCnt        = pwm_cnt_q;
  assign pwmStart      = (state_q == ST_RUN) && (pwm_cnt_q == 16'd0);
  assign stepStart     = pwmStart && (per_cnt_q == 16'd0);
  assign lineCycleDone = line_done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
